stencil_delay_bank: RTL

STENCIL_DELAY_BANK -- requirements
Module: stencil_delay_bank

---
 rtl/stencil_delay_bank.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stencil_delay_bank.sv
// stencil_delay_bank: circular word store with NREAD independent delay taps.
// A tap with delay d returns the word written d pushes ago, one cycle later.
// Optional build macro STENCIL_DELAY_BANK_ERR_EN adds a sticky err output
// that flags read requests made with an out-of-range delay.
module stencil_delay_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2054,
  parameter int NREAD = 5,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wen,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       ren,
  input  logic [NREAD*AW-1:0]    rdelay,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rvalid,
  output logic [AW-1:0]          fill,
  output logic                   full
`ifdef STENCIL_DELAY_BANK_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [AW-1:0]          waddr_q, waddr_d;
  logic [AW-1:0]          fill_q, fill_d;
  logic [NREAD-1:0]       rvalid_q, rvalid_d;
  logic [NREAD*WIDTH-1:0] rdata_q, rdata_d;
  logic [NREAD-1:0]       tap_legal;

  // (waddr + DEPTH - d) mod DEPTH with one conditional subtract; the sum
  // never exceeds 2*DEPTH-1 for legal delays, so AW+1 bits suffice.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] wa,
                                             input logic [AW-1:0] d);
    logic [AW:0] sum;
    sum = {1'b0, wa} + DEPTH_W - {1'b0, d};
    if (sum >= DEPTH_W) sum = sum - DEPTH_W;
    return sum[AW-1:0];
  endfunction

  // Write pointer and fill count; flush wins over a same-cycle write.
  always_comb begin
    waddr_d = waddr_q;
    fill_d  = fill_q;
    if (flush) begin
      waddr_d = '0;
      fill_d  = '0;
    end else if (wen) begin
      waddr_d = (waddr_q == LAST_A) ? '0 : waddr_q + 1'b1;
      if (fill_q != DEPTH_A) fill_d = fill_q + 1'b1;
    end
  end

  // Per-tap legality, address and next read word; illegal or idle taps hold rdata.
  always_comb begin
    logic [AW-1:0] d_i;
    logic [AW-1:0] a_i;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    tap_legal = '0;
    d_i       = '0;
    a_i       = '0;
    for (int i = 0; i < NREAD; i++) begin
      d_i          = rdelay[i*AW +: AW];
      a_i          = tap_addr(waddr_q, d_i);
      tap_legal[i] = (d_i != '0) && (d_i <= fill_q);
      if (ren[i] && tap_legal[i] && !flush) begin
        rvalid_d[i]                = 1'b1;
        rdata_d[i*WIDTH +: WIDTH]  = mem[a_i[IW-1:0]];
      end
    end
  end

  // Control and read-port registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr_q  <= '0;
      fill_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      waddr_q  <= waddr_d;
      fill_q   <= fill_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array: never reset, reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (wen && !flush) mem[waddr_q[IW-1:0]] <= wdata;
  end

`ifdef STENCIL_DELAY_BANK_ERR_EN
  logic err_q, err_d;

  // Sticky error: any requested tap with an illegal delay; flush clears it.
  always_comb begin
    err_d = err_q;
    if (flush)                  err_d = 1'b0;
    else if (|(ren & ~tap_legal)) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign fill   = fill_q;
  assign full   = (fill_q == DEPTH_A);

endmodule
